// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu - load/store unit, initiator side of the data-memory request interface.
//
// Turns a core byte/half/word load or store into one word-aligned memory
// transaction with byte enables, stalls the core until the memory answers,
// then returns the lane-extracted, sign/zero-extended load data.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   core_req_i         access request (held while core_stall_o=1)
//   core_we_i          1=store, 0=load
//   core_size_i        funct3 size/sign encoding
//   core_addr_i        byte address
//   core_wd_i          right-aligned store data
//   core_rd_o          load result, valid in the release cycle only
//   core_stall_o       core must hold request and operands
//   core_fault_o       misaligned/illegal access, no memory request made
//   mem_req_o          memory request (single cycle per access)
//   mem_we_o           memory write enable
//   mem_be_o           byte enables
//   mem_addr_o         byte address (memory ignores [1:0])
//   mem_wd_o           lane-replicated store data
//   mem_rd_i           memory read word
//   mem_ready_i        memory response valid
// ----------------------------------------------------------------------------
module lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [1:0]  r_off;
    logic [2:0]  r_size;
    logic        r_we;
    logic        w_fault;
    logic        w_issue;
    logic [31:0] w_byte_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Alignment / encoding check on the live request
    always_comb begin
        w_fault = 1'b0;
        case (core_size_i)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = core_addr_i[0];
            3'b010:  w_fault = (core_addr_i[1:0] != 2'b00);
            3'b100:  w_fault = core_we_i;
            3'b101:  w_fault = core_addr_i[0] | core_we_i;
            default: w_fault = 1'b1;
        endcase
    end

    assign w_issue = (r_state == ST_IDLE) && core_req_i && !w_fault;

    // Address-side outputs follow the inputs; only req/we are qualified
    assign mem_addr_o = core_addr_i;

    always_comb begin
        mem_be_o = 4'b0000;
        mem_wd_o = core_wd_i;
        case (core_size_i[1:0])
            2'b00: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            2'b10: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
            default: begin
                mem_be_o = 4'b0000;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    // Load extraction from the latched offset/size
    assign w_byte_shift = mem_rd_i >> {r_off, 3'b000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_half       = r_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        w_load = 32'h0;
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            3'b010:  w_load = mem_rd_i;
            default: w_load = 32'h0;
        endcase
    end

    // Control outputs are gated by rst_ni so an asserted reset silences the
    // interface in the same cycle, even while the core still holds its request.
    always_comb begin
        core_stall_o = 1'b0;
        core_fault_o = 1'b0;
        core_rd_o    = 32'h0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        if (rst_ni) begin
            if (r_state == ST_IDLE) begin
                if (core_req_i) begin
                    if (w_fault) begin
                        core_fault_o = 1'b1;
                    end else begin
                        mem_req_o    = 1'b1;
                        mem_we_o     = core_we_i;
                        core_stall_o = 1'b1;
                    end
                end
            end else begin
                core_stall_o = !mem_ready_i;
                if (mem_ready_i && !r_we) begin
                    core_rd_o = w_load;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE) begin
            if (w_issue) begin
                w_state_nxt = ST_BUSY;
            end
        end else if (mem_ready_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_off   <= 2'b00;
            r_size  <= 3'b000;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_off  <= core_addr_i[1:0];
                r_size <= core_size_i;
                r_we   <= core_we_i;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu - scoreboard bench for lsu. The driver pushes the expected memory
// issue and the expected core response for each directed vector; a monitor
// on the falling edge pops and compares whenever the DUT issues, faults or
// releases. A small word-array memory with programmable response delay
// stands in for data memory.
// ----------------------------------------------------------------------------
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'b000;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    lsu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_fault_o (core_fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
    } issue_t;

    typedef struct {
        logic        fault;
        logic [31:0] rd;
    } resp_t;

    issue_t issue_q[$];
    resp_t  resp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [16] = '{default: 32'h0};
    int          ready_delay = 0;
    int          r_cnt;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= 0;
            mem_ready_i <= 1'b0;
            mem_rd_i    <= 32'h0;
        end else if (mem_req_o) begin
            mem_rd_i    <= mem[mem_addr_o[5:2]];
            mem_ready_i <= (ready_delay == 0);
            r_cnt       <= ready_delay;
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) mem[mem_addr_o[5:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
                end
            end
        end else if (r_cnt != 0) begin
            r_cnt       <= r_cnt - 1;
            mem_ready_i <= (r_cnt == 1);
        end else begin
            mem_ready_i <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_req_o) begin
                if (issue_q.size() == 0) begin
                    check("unexpected_issue", 32'(mem_req_o), 32'h0);
                end else begin
                    issue_t e;
                    e = issue_q.pop_front();
                    check("issue_we", 32'(mem_we_o), 32'(e.we));
                    check("issue_be", 32'(mem_be_o), 32'(e.be));
                    check("issue_wd", mem_wd_o, e.wd);
                    check("issue_addr", mem_addr_o, e.addr);
                end
            end
            if (core_req_i && (core_fault_o || !core_stall_o)) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", 32'(core_fault_o), 32'h0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_fault", 32'(core_fault_o), 32'(r.fault));
                    check("resp_rd", core_rd_o, r.rd);
                    if (core_fault_o) begin
                        check("fault_no_req", 32'(mem_req_o), 32'h0);
                        check("fault_no_stall", 32'(core_stall_o), 32'h0);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Call #1 after a rising edge with the DUT idle. Returns cycles taken.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic fault, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input int delay, input logic keep, output int cycles);
        issue_t e;
        resp_t  r;
        ready_delay = delay;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        if (!fault) begin
            e.we = we; e.be = exp_be; e.wd = exp_wd; e.addr = addr;
            issue_q.push_back(e);
        end
        r.fault = fault;
        r.rd    = exp_rd;
        resp_q.push_back(r);
        cycles = 0;
        forever begin
            @(negedge clk_i);
            cycles++;
            if (core_fault_o || !core_stall_o) break;
            if (cycles > 1) begin
                check("busy_no_reissue", 32'(mem_req_o), 32'h0);
            end
            if (cycles > 20) begin
                check("timeout", 32'(cycles), 32'(delay + 2));
                break;
            end
        end
        @(posedge clk_i);
        #1;
        if (!keep) core_req_i = 1'b0;
    endtask

    int cyc;
    int cyc2;

    initial begin
        // Reset state, with a legal request already presented
        core_req_i  = 1'b1;
        core_size_i = 3'b010;
        core_addr_i = 32'h10;
        #12;
        check("rst_stall", 32'(core_stall_o), 32'h0);
        check("rst_mem_req", 32'(mem_req_o), 32'h0);
        check("rst_fault", 32'(core_fault_o), 32'h0);
        check("rst_rd", core_rd_o, 32'h0);
        core_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_mem_we", 32'(mem_we_o), 32'h0);

        // Word store / load
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 1'b0, cyc);
        check("sw_cycles", 32'(cyc), 32'd2);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 1'b0, cyc);
        // Byte lanes: word 4 becomes 0xA5ADBEEF
        access(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 1'b0, cyc);
        access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFFA5, 0, 1'b0, cyc);
        access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 4'b1000, 32'h0, 32'h000000A5, 0, 1'b0, cyc);
        access(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 4'b0010, 32'h0, 32'hFFFFFFBE, 0, 1'b0, cyc);
        access(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 4'b1100, 32'h0, 32'h0000A5AD, 0, 1'b0, cyc);
        // Halfword: word 8 becomes 0x80010000
        access(1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0, 4'b1100, 32'h80018001, 32'h0, 0, 1'b0, cyc);
        access(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001, 0, 1'b0, cyc);
        access(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 4'b1100, 32'h0, 32'h00008001, 0, 1'b0, cyc);
        access(1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 4'b0011, 32'h0, 32'h00000000, 0, 1'b0, cyc);
        // Faults
        access(1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0, cyc);
        check("fault_cycles", 32'(cyc), 32'd1);
        access(1'b0, 3'b001, 32'h03, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0, cyc);
        access(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0, cyc);
        access(1'b1, 3'b100, 32'h00, 32'h5A, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0, cyc);
        // Delayed ready
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hA5ADBEEF, 3, 1'b0, cyc);
        check("delay_cycles", 32'(cyc), 32'd5);
        // Back-to-back with request held high
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hA5ADBEEF, 0, 1'b1, cyc);
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h80010000, 0, 1'b0, cyc2);
        check("b2b_cycles", 32'(cyc + cyc2), 32'd4);

        // Reset during BUSY: response discarded
        begin
            issue_t e;
            ready_delay = 3;
            core_req_i  = 1'b1;
            core_we_i   = 1'b0;
            core_size_i = 3'b010;
            core_addr_i = 32'h10;
            e.we = 1'b0; e.be = 4'b1111; e.wd = 32'h0; e.addr = 32'h10;
            issue_q.push_back(e);
            @(posedge clk_i);
            #1;
            check("busy_stall", 32'(core_stall_o), 32'h1);
            rst_ni = 1'b0;
            #1;
            check("rst_busy_stall", 32'(core_stall_o), 32'h0);
            check("rst_busy_req", 32'(mem_req_o), 32'h0);
            core_req_i = 1'b0;
            @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
            @(posedge clk_i);
            #1;
        end
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h80010000, 0, 1'b0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd2);

        repeat (2) @(posedge clk_i);
        check("issue_q_drained", 32'(issue_q.size()), 32'h0);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
